// File: rtl/spi_slave.sv
// SPI slave with per-frame CPOL/CPHA, synchronized inputs and a registered receive byte.
// Optional sticky overrun detection is enabled by defining SPI_SLAVE_OVERRUN_DET_EN.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, warm_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic                   mode_cpol_q, mode_cpol_d, mode_cpha_q, mode_cpha_d;
  logic [7:0]             tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   skip_q, skip_d, done_q, done_d, rx_valid_q, rx_valid_d;

  logic sclk_cur, ss_cur, mosi_cur;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      warm_q      <= '0;
      sclk_prev_q <= cpol;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_cur;
      ss_prev_q   <= ss_cur;
    end
  end

  always_comb begin
    sclk_cur    = sclk_sync_q[SYNC_STAGES-1];
    ss_cur      = ss_sync_q[SYNC_STAGES-1];
    mosi_cur    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise   = sclk_cur & ~sclk_prev_q;
    sclk_fall   = ~sclk_cur & sclk_prev_q;
    lead_edge   = mode_cpol_q ? sclk_fall : sclk_rise;
    trail_edge  = mode_cpol_q ? sclk_rise : sclk_fall;
    sample_edge = mode_cpha_q ? trail_edge : lead_edge;
    shift_edge  = mode_cpha_q ? lead_edge : trail_edge;
    // A fall only counts once SS has been seen high after reset, so a frame cut by
    // reset cannot restart without a fresh SS fall.
    ss_fall     = armed_q & ss_prev_q & ~ss_cur;
    ss_rise     = ~ss_prev_q & ss_cur;
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | (warm_q[SYNC_STAGES-1] & ss_cur);
    mode_cpol_d = mode_cpol_q;
    mode_cpha_d = mode_cpha_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d     = StActive;
          mode_cpol_d = cpol;
          mode_cpha_d = cpha;
          tx_sr_d     = tx_data;
          cnt_d       = 3'd0;
          // With cpha=1 the first shift edge presents bit 7 rather than shifting it out.
          skip_d      = cpha;
        end
      end
      StActive: begin
        if (ss_rise) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          if (shift_edge) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[6:0], mosi_cur};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d  = 1'b1;
              tx_sr_d = tx_data;
              skip_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (done_q) begin
      rx_data_d  = rx_sr_q;
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      mode_cpol_q <= 1'b0;
      mode_cpha_q <= 1'b0;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      cnt_q       <= 3'd0;
      skip_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      mode_cpol_q <= mode_cpol_d;
      mode_cpha_q <= mode_cpha_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      done_q      <= done_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_DET_EN
  logic overrun_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (done_q && rx_valid_q && !rx_ack) begin
      overrun_q <= 1'b1;
    end
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign MISO     = (state_q == StActive) & tx_sr_q[7];
  assign busy     = (state_q == StActive);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master in all four modes.
module tb_spi_slave;

  localparam int unsigned SYNC = 2;
  localparam int          H    = 8;  // SCLK half period in clk cycles

  logic       clk, reset, SCLK, SS, MOSI, MISO, cpol, cpha, rx_valid, rx_ack, busy, overrun;
  logic [7:0] tx_data, rx_data, got;
  logic       m_cpol, m_cpha, lat_chk, exp_ovr;
  int         n_tests, n_fail;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic a);
    cpol = p; cpha = a; m_cpol = p; m_cpha = a; SCLK = p;
    clk_wait(H);
  endtask

  task automatic ss_low();
    SS = 1'b0;
    clk_wait(2 * H);
  endtask

  task automatic ss_high();
    clk_wait(H);
    SS = 1'b1;
    clk_wait(2 * H);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    clk_wait(1);
    rx_ack = 1'b0;
    clk_wait(1);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m_cpha) begin
        MOSI = mo[i];
        clk_wait(H);
        SCLK = ~m_cpol;
        mi = {mi[6:0], MISO};
        if (lat_chk && i == 0) begin
          clk_wait(SYNC + 1);
          check_eq("latency_lo", rx_valid, 0);
          clk_wait(1);
          check_eq("latency_hi", rx_valid, 1);
          clk_wait(H - SYNC - 2);
        end else begin
          clk_wait(H);
        end
        SCLK = m_cpol;
      end else begin
        SCLK = ~m_cpol;
        MOSI = mo[i];
        clk_wait(H);
        SCLK = m_cpol;
        mi = {mi[6:0], MISO};
        clk_wait(H);
      end
    end
    if (!m_cpha) clk_wait(H);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; lat_chk = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    reset = 1'b1; SS = 1'b1; MOSI = 1'b0; SCLK = 1'b0; cpol = 1'b0; cpha = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
    clk_wait(4);
    reset = 1'b0;
    clk_wait(10);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_miso", MISO, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);

    // Mode 0 single byte with latency check
    set_mode(1'b0, 1'b0);
    tx_data = 8'h3C;
    ss_low();
    check_eq("m0_busy", busy, 1);
    lat_chk = 1'b1;
    xfer(8'hA5, 8, got);
    lat_chk = 1'b0;
    check_eq("m0_rx_data", rx_data, 8'hA5);
    check_eq("m0_miso_byte", got, 8'h3C);
    ss_high();
    check_eq("m0_idle_miso", MISO, 0);
    check_eq("m0_valid_held", rx_valid, 1);
    ack();
    check_eq("m0_ack_clears", rx_valid, 0);
    ack();
    check_eq("m0_ack_idle_valid", rx_valid, 0);
    check_eq("m0_ack_idle_data", rx_data, 8'hA5);

    // Modes 1..3 with 0x81
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_data = 8'h81;
      ss_low();
      xfer(8'h81, 8, got);
      ss_high();
      check_eq($sformatf("mode%0d_rx", m), rx_data, 8'h81);
      check_eq($sformatf("mode%0d_miso", m), got, 8'h81);
      check_eq($sformatf("mode%0d_valid", m), rx_valid, 1);
      ack();
    end

    // Back-to-back bytes in one frame
    set_mode(1'b0, 1'b0);
    tx_data = 8'h9A;
    ss_low();
    tx_data = 8'h56;
    xfer(8'h12, 8, got);
    check_eq("b2b_rx1", rx_data, 8'h12);
    check_eq("b2b_miso1", got, 8'h9A);
    ack();
    xfer(8'h34, 8, got);
    check_eq("b2b_rx2", rx_data, 8'h34);
    check_eq("b2b_miso2", got, 8'h56);
    ss_high();
    ack();

    // Partial byte aborted by SS rise
    ss_low();
    xfer(8'hFF, 5, got);
    ss_high();
    check_eq("partial_valid", rx_valid, 0);
    check_eq("partial_data", rx_data, 8'h34);
    ss_low();
    xfer(8'h0F, 8, got);
    ss_high();
    check_eq("after_partial_rx", rx_data, 8'h0F);
    check_eq("after_partial_valid", rx_valid, 1);
    ack();
    check_eq("no_overrun_yet", overrun, 0);

    // Two bytes without acknowledge
    ss_low();
    xfer(8'h11, 8, got);
    xfer(8'h22, 8, got);
    ss_high();
    check_eq("ovr_rx_data", rx_data, 8'h22);
    check_eq("ovr_valid", rx_valid, 1);
    check_eq("ovr_flag", overrun, exp_ovr);

    // Reset mid-frame
    tx_data = 8'hC3;
    ss_low();
    xfer(8'hC3, 3, got);
    reset = 1'b1;
    clk_wait(1);
    reset = 1'b0;
    check_eq("midrst_rx_data", rx_data, 8'h00);
    check_eq("midrst_valid", rx_valid, 0);
    check_eq("midrst_overrun", overrun, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_miso", MISO, 0);
    xfer(8'hFF, 8, got);
    check_eq("midrst_no_resume_busy", busy, 0);
    check_eq("midrst_no_resume_valid", rx_valid, 0);
    ss_high();
    ss_low();
    xfer(8'hC3, 8, got);
    ss_high();
    check_eq("post_rst_rx", rx_data, 8'hC3);
    check_eq("post_rst_miso", got, 8'hC3);
    check_eq("post_rst_valid", rx_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
